// File: rtl/textbuf_pkg.sv
// Shared constants and types for the textbuf single-line text buffer.
package textbuf_pkg;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_TILDE = 8'h7E;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= CH_SPACE) && (c <= CH_TILDE);
  endfunction

endpackage

// File: rtl/textbuf.sv
// Single-line text buffer: ASCII byte stream in, COLS character cells out.
// Define TEXTBUF_DOUBLE_BUFFER_EN to present cells through a vsync-loaded display copy.
module textbuf
  import textbuf_pkg::*;
#(
  parameter int COLS = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [7:0]                in_data,
  input  logic                      vsync,
  output logic [7:0]                chars [0:COLS-1],
  output logic [$clog2(COLS)-1:0]   cursor,
  output logic                      busy
);

  localparam int AW = $clog2(COLS);
  localparam logic [AW-1:0] LAST = AW'(COLS - 1);

  state_t          state, state_nxt;
  logic [AW-1:0]   clr_idx;
  logic [7:0]      cells [0:COLS-1];
  logic            accept;
  logic            wr_en;
  logic [AW-1:0]   wr_idx;
  logic [7:0]      wr_data;
  logic [AW-1:0]   cursor_nxt;

  assign accept = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept && in_data == CH_FF) state_nxt = CLEAR;
      CLEAR: if (clr_idx == LAST)            state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      CLEAR:   busy     = 1'b1;
      default: in_ready = 1'b1;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    wr_en      = 1'b0;
    wr_idx     = clr_idx;
    wr_data    = CH_SPACE;
    cursor_nxt = cursor;
    if (state == CLEAR) begin
      wr_en = 1'b1;
      if (clr_idx == LAST) cursor_nxt = '0;
    end else if (accept) begin
      if (is_printable(in_data)) begin
        wr_en      = 1'b1;
        wr_idx     = cursor;
        wr_data    = in_data;
        cursor_nxt = cursor + AW'(1);
      end else if (in_data == CH_BS) begin
        if (cursor != '0) begin
          wr_en      = 1'b1;
          wr_idx     = cursor - AW'(1);
          cursor_nxt = cursor - AW'(1);
        end
      end else if (in_data == CH_CR) begin
        cursor_nxt = '0;
      end
    end
  end

  // Clear sweep index idles at zero and wraps to zero naturally after the last cell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_idx <= '0;
      cursor  <= '0;
    end else begin
      clr_idx <= (state == CLEAR) ? clr_idx + AW'(1) : '0;
      cursor  <= cursor_nxt;
    end
  end

  // NOTE: the cell array is reset because a blank line after reset is visible behaviour, not just init.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < COLS; i++) cells[i] <= CH_SPACE;
    end else if (wr_en) begin
      cells[wr_idx] <= wr_data;
    end
  end

`ifdef TEXTBUF_DOUBLE_BUFFER_EN
  logic copy_pend;
  logic load;

  // A vsync seen during a clear is remembered and serviced on the first idle cycle.
  assign load = (state == IDLE) && (vsync || copy_pend);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < COLS; i++) chars[i] <= CH_SPACE;
      copy_pend <= 1'b0;
    end else begin
      if (load) begin
        for (int i = 0; i < COLS; i++) chars[i] <= cells[i];
      end
      if (state == CLEAR && vsync) copy_pend <= 1'b1;
      else if (load)               copy_pend <= 1'b0;
    end
  end
`else
  logic vsync_unused;

  assign vsync_unused = vsync;
  assign chars        = cells;
`endif

endmodule

// File: tb/tb_textbuf.sv
// Directed self-checking bench for textbuf (COLS=32), either buffering build.
module tb_textbuf;

  localparam int COLS = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        vsync;
  logic [7:0]  chars [0:COLS-1];
  logic [4:0]  cursor;
  logic        busy;

  int n_total = 0;
  int n_bad   = 0;

  textbuf #(.COLS(COLS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .vsync    (vsync),
    .chars    (chars),
    .cursor   (cursor),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  // Pulse vsync for one idle cycle; the direct build ignores it.
  task automatic show();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
  endtask

  function automatic int count_nonblank();
    int n = 0;
    for (int i = 0; i < COLS; i++) if (chars[i] != 8'h20) n++;
    return n;
  endfunction

  // Waits for busy to drop, returning how many samples showed busy high (first sample included).
  task automatic wait_clear(input string tag, output int hi, output int nrdy);
    bit done = 0;
    hi   = 1;
    nrdy = in_ready ? 0 : 1;
    for (int k = 0; k < 100 && !done; k++) begin
      tick();
      if (busy) begin
        hi++;
        if (!in_ready) nrdy++;
      end else begin
        done = 1;
      end
    end
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int hi, nrdy;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    vsync    = 1'b0;

    // Reset state
    #12;
    check("rst_ready",  32'(in_ready), 32'd1);
    check("rst_busy",   32'(busy),     32'd0);
    check("rst_cursor", 32'(cursor),   32'd0);
    check("rst_blank",  32'(count_nonblank()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // "ab"
    push(8'h61);
    push(8'h62);
    show();
    check("ab_c0",     32'(chars[0]), 32'h61);
    check("ab_c1",     32'(chars[1]), 32'h62);
    check("ab_c2",     32'(chars[2]), 32'h20);
    check("ab_cursor", 32'(cursor),   32'd2);

    // Backspace twice, then once more at column 0
    push(8'h08);
    check("bs1_cursor", 32'(cursor), 32'd1);
    push(8'h08);
    check("bs2_cursor", 32'(cursor), 32'd0);
    push(8'h08);
    show();
    check("bs3_cursor", 32'(cursor),   32'd0);
    check("bs_c0",      32'(chars[0]), 32'h20);
    check("bs_c1",      32'(chars[1]), 32'h20);

    // Carriage return keeps cells
    push(8'h71);
    push(8'h72);
    push(8'h0D);
    show();
    check("cr_cursor", 32'(cursor),   32'd0);
    check("cr_c0",     32'(chars[0]), 32'h71);
    check("cr_c1",     32'(chars[1]), 32'h72);

    // COLS+1 printable bytes: wrap overwrites cell 0
    for (int i = 0; i <= COLS; i++) push(8'(8'h30 + i));
    show();
    check("wrap_c0",     32'(chars[0]),  32'h50);
    check("wrap_c1",     32'(chars[1]),  32'h31);
    check("wrap_c31",    32'(chars[31]), 32'h4F);
    check("wrap_cursor", 32'(cursor),    32'd1);

    // Unrecognised control byte is consumed without effect
    push(8'h01);
    show();
    check("ign_cursor", 32'(cursor),   32'd1);
    check("ign_c1",     32'(chars[1]), 32'h31);
    check("ign_ready",  32'(in_ready), 32'd1);

    // Form feed with valid held and "x" queued behind it
    in_valid = 1'b1;
    in_data  = 8'h0C;
    tick();
    in_data = 8'h78;
    check("ff_busy",  32'(busy),     32'd1);
    check("ff_ready", 32'(in_ready), 32'd0);
    wait_clear("ff", hi, nrdy);
    check("ff_busy_cycles",  32'(hi),   32'd32);
    check("ff_stall_cycles", 32'(nrdy), 32'd32);
    check("ff_end_cursor",   32'(cursor), 32'd0);
`ifndef TEXTBUF_DOUBLE_BUFFER_EN
    check("ff_blank", 32'(count_nonblank()), 32'd0);
`endif
    tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
    show();
    check("ffx_c0",     32'(chars[0]), 32'h78);
    check("ffx_c1",     32'(chars[1]), 32'h20);
    check("ffx_cursor", 32'(cursor),   32'd1);
    check("ffx_blank",  32'(count_nonblank()), 32'd1);

`ifdef TEXTBUF_DOUBLE_BUFFER_EN
    // Shadow write is hidden until vsync
    push(8'h0D);
    push(8'h7A);
    check("db_hold0", 32'(chars[0]), 32'h78);
    tick();
    tick();
    check("db_hold1", 32'(chars[0]), 32'h78);
    show();
    check("db_load", 32'(chars[0]), 32'h7A);

    // vsync during CLEAR is deferred to the first idle cycle
    push(8'h0C);
    tick();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    check("db_pend_c0", 32'(chars[0]), 32'h7A);
    wait_clear("db", hi, nrdy);
    check("db_pre_copy", 32'(chars[0]), 32'h7A);
    tick();
    check("db_post_copy", 32'(chars[0]), 32'h20);
    check("db_blank",     32'(count_nonblank()), 32'd0);
`endif

    // Reset in the middle of a clear
    push(8'h0D);
    push(8'h6B);
    push(8'h6D);
    show();
    push(8'h0C);
    tick();
    tick();
    check("mid_busy_pre", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",   32'(busy),     32'd0);
    check("mid_rst_ready",  32'(in_ready), 32'd1);
    check("mid_rst_cursor", 32'(cursor),   32'd0);
    check("mid_rst_blank",  32'(count_nonblank()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_busy",  32'(busy),   32'd0);
    check("post_rst_blank", 32'(count_nonblank()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
